// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: single-byte I2C master bit engine (START, addr+RW, data, STOP).
// Optional I2C_CLK_STRETCH_EN adds scl_i so a slave can stretch SCL high quarters.
module i2c_bit_engine #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       finish,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       scl_i,
`endif
  input  logic       sda_i
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA,
    WACK, RDATA, RNACK, STOP, DONE
  } state_t;

  state_t state, nstate;

  logic [PW-1:0] presc;
  logic [1:0]    q;
  logic [2:0]    cnt;
  logic          rw_q;
  logic [6:0]    addr_q;
  logic [7:0]    wd_q;
  logic [7:0]    sh;
  logic [7:0]    abyte;
  logic          accept, active, hold, tick;
  logic          sample, slot_end, last_bit;
  logic          data_st, dscl;

  assign accept   = (state == IDLE) && start;
  assign active   = (state != IDLE) && (state != DONE);
  assign busy     = active;
  assign finish   = (state == DONE);

`ifdef I2C_CLK_STRETCH_EN
  assign hold = active && !scl_oe && (q == 2'd1 || q == 2'd2) && !scl_i;
`else
  assign hold = 1'b0;
`endif

  assign tick     = active && !hold && (presc == PMAX);
  assign sample   = tick && (q == 2'd2);
  assign slot_end = tick && (q == 2'd3);
  assign last_bit = slot_end && (cnt == 3'd0);
  assign data_st  = (state == ADDR) || (state == WDATA) || (state == RDATA);
  assign abyte    = {addr_q, rw_q};
  assign dscl     = (q == 2'd0) || (q == 2'd3);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // prescaler, quarter counter and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      q     <= 2'd0;
      cnt   <= 3'd0;
    end else if (accept) begin
      presc <= '0;
      q     <= 2'd0;
    end else if (active && !hold) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) q <= q + 2'd1;
      if (slot_end) cnt <= data_st ? cnt - 3'd1 : 3'd7;
    end
  end

  // request latch, ack status and read shifter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= 1'b0;
      addr_q  <= 7'd0;
      wd_q    <= 8'd0;
      ack_err <= 1'b0;
      sh      <= 8'd0;
      rd_data <= 8'd0;
    end else begin
      if (accept) begin
        rw_q    <= rw;
        addr_q  <= dev_addr;
        wd_q    <= wr_data;
        ack_err <= 1'b0;
      end
      if (sample && sda_i && (state == ADDR_ACK || state == WACK))
        ack_err <= 1'b1;
      if (sample && state == RDATA)
        sh <= {sh[6:0], sda_i};
      if (slot_end && state == STOP && rw_q && !ack_err)
        rd_data <= sh;
    end
  end

  // next state and pad enables
  always_comb begin
    nstate = state;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state)
      IDLE: if (start) nstate = START;
      START: begin
        scl_oe = (q == 2'd3);
        sda_oe = (q == 2'd2) || (q == 2'd3);
        if (slot_end) nstate = ADDR;
      end
      ADDR: begin
        scl_oe = dscl;
        sda_oe = ~abyte[cnt];
        if (last_bit) nstate = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_oe = dscl;
        if (slot_end)
          nstate = ack_err ? STOP : (rw_q ? RDATA : WDATA);
      end
      WDATA: begin
        scl_oe = dscl;
        sda_oe = ~wd_q[cnt];
        if (last_bit) nstate = WACK;
      end
      WACK: begin
        scl_oe = dscl;
        if (slot_end) nstate = STOP;
      end
      RDATA: begin
        scl_oe = dscl;
        if (last_bit) nstate = RNACK;
      end
      RNACK: begin
        scl_oe = dscl;
        if (slot_end) nstate = STOP;
      end
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q == 2'd0) || (q == 2'd1);
        if (slot_end) nstate = DONE;
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb_i2c_bit_engine: slot-level I2C model checked against the engine every cycle.
// Also covers CLK_DIV=2, reset mid-transfer and (with I2C_CLK_STRETCH_EN) stretching.
module tb_i2c_bit_engine;

  localparam int C = 4;
  localparam int T_START = 0;
  localparam int T_BIT   = 1;
  localparam int T_REL   = 2;
  localparam int T_STOP  = 3;

  logic       clk;
  logic       reset, start, rw, sda_i;
  logic [6:0] dev_addr;
  logic [7:0] wr_data, rd_data;
  logic       busy, finish, ack_err, scl_oe, sda_oe;
`ifdef I2C_CLK_STRETCH_EN
  logic       scl_i;
`endif

  logic       start2, sda_i2;
  logic [7:0] rd_data2;
  logic       busy2, finish2, ack_err2, scl_oe2, sda_oe2;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] rd_prev;
  logic       cap[$];

  i2c_bit_engine #(.CLK_DIV(C)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .dev_addr(dev_addr), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .finish(finish), .ack_err(ack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
`ifdef I2C_CLK_STRETCH_EN
    .scl_i(scl_i),
`endif
    .sda_i(sda_i)
  );

  i2c_bit_engine #(.CLK_DIV(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .rw(1'b0),
    .dev_addr(7'h11), .wr_data(8'h00), .rd_data(rd_data2),
    .busy(busy2), .finish(finish2), .ack_err(ack_err2),
    .scl_oe(scl_oe2), .sda_oe(sda_oe2),
`ifdef I2C_CLK_STRETCH_EN
    .scl_i(1'b1),
`endif
    .sda_i(sda_i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pack8(input int i0);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = cap[i0+i];
    return v;
  endfunction

  // one transaction: build slot list, then check every cycle to finish
  task automatic run_txn(input logic r, input logic [6:0] a,
                         input logic [7:0] wd, input logic [7:0] rb,
                         input logic aack, input logic dack,
                         input bit keep, input int poke, input int lat);
    int         st[20];
    logic       sb[20];
    logic       sp[20];
    int         n, L, s, qq, fin_at;
    logic [7:0] ab;
    logic [3:0] ev;
    logic       pull, pscl, es, ed;
    ab = {a, r};
    st[0] = T_START; sb[0] = 1'b0; sp[0] = 1'b0; n = 1;
    for (int i = 7; i >= 0; i--) begin
      st[n] = T_BIT; sb[n] = ab[i]; sp[n] = 1'b0; n++;
    end
    st[n] = T_REL; sb[n] = 1'b0; sp[n] = aack; n++;
    if (aack) begin
      for (int i = 7; i >= 0; i--) begin
        st[n] = r ? T_REL : T_BIT;
        sb[n] = wd[i];
        sp[n] = r ? ~rb[i] : 1'b0;
        n++;
      end
      st[n] = T_REL; sb[n] = 1'b0; sp[n] = r ? 1'b0 : dack; n++;
    end
    st[n] = T_STOP; sb[n] = 1'b0; sp[n] = 1'b0; n++;
    L = n * 4 * C + 1;
    cap.delete();
    fin_at = 0;
    pscl = 1'b0;
    rw = r; dev_addr = a; wr_data = wd; start = 1'b1;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      start = keep ? 1'b1 : (k == poke);
      if (k == L) begin
        ev = 4'b0001;
        pull = 1'b0;
      end else begin
        s  = (k - 1) / (4 * C);
        qq = ((k - 1) % (4 * C)) / C;
        pull = sp[s];
        case (st[s])
          T_START: begin es = (qq == 3); ed = (qq >= 2); end
          T_BIT:   begin es = (qq == 0 || qq == 3); ed = ~sb[s]; end
          T_REL:   begin es = (qq == 0 || qq == 3); ed = 1'b0; end
          default: begin es = (qq == 0); ed = (qq <= 1); end
        endcase
        ev = {es, ed, 2'b10};
      end
      sda_i = !(pull || sda_oe);
      if (pscl && !scl_oe) cap.push_back(sda_i);
      pscl = scl_oe;
      chk($sformatf("cycle%0d", k), {scl_oe, sda_oe, busy, finish}, ev);
      if (finish && fin_at == 0) fin_at = k;
    end
    chk("latency", fin_at, lat);
    chk("ack_err", ack_err, !aack || (!r && !dack));
    if (r && aack) rd_prev = rb;
    chk("rd_data", rd_data, rd_prev);
  endtask

  task automatic run2(input logic sv, input int lat, input logic err);
    int fin_at;
    fin_at = 0;
    sda_i2 = sv;
    start2 = 1'b1;
    for (int k = 1; k <= 400 && fin_at == 0; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (finish2) fin_at = k;
    end
    chk("div2_lat", fin_at, lat);
    chk("div2_err", ack_err2, err);
    @(negedge clk);
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic run_stretch();
    int fin_at;
    fin_at = 0;
    rw = 1'b0; dev_addr = 7'h50; wr_data = 8'h00; start = 1'b1;
    for (int k = 1; k <= 600 && fin_at == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      sda_i = !sda_oe;
      scl_i = !(scl_oe || (k >= 53 && k <= 62));
      if (finish) fin_at = k;
    end
    scl_i = 1'b1;
    chk("stretch_lat", fin_at, 187);
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; sda_i = 1'b1;
    dev_addr = 7'd0; wr_data = 8'd0; rd_prev = 8'd0;
    start2 = 1'b0; sda_i2 = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
    scl_i = 1'b1;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out", {scl_oe, sda_oe, busy, finish, ack_err}, 5'b0);
    chk("rst_rd", rd_data, 8'h00);
    chk("rst_out2", {scl_oe2, sda_oe2, busy2, finish2, ack_err2}, 5'b0);

    // write with a stray start pulse mid-transfer
    run_txn(1'b0, 7'h50, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 100, 321);
    chk("addr_bits", pack8(0), 8'hA0);
    chk("wdata_bits", pack8(9), 8'hA5);
    @(negedge clk);

    run_txn(1'b1, 7'h68, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 321);
    chk("rd_lit", rd_data, 8'h3C);
    chk("raddr_bits", pack8(0), 8'hD1);
    chk("rbus_bits", pack8(9), 8'h3C);
    chk("rnack_bit", cap[17], 1'b1);
    @(negedge clk);

    run_txn(1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 0, 177);
    chk("nack_err_lit", ack_err, 1'b1);
    chk("nack_rd_keep", rd_data, 8'h3C);
    chk("nack_edges", cap.size(), 10);
    @(negedge clk);
    chk("err_held", ack_err, 1'b1);

    run_txn(1'b0, 7'h3B, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 0, 321);
    chk("dnack_err_lit", ack_err, 1'b1);
    @(negedge clk);

    // start held high through DONE
    run_txn(1'b0, 7'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 0, 321);
    @(negedge clk);
    chk("reacc_idle", {busy, finish}, 2'b00);
    run_txn(1'b1, 7'h12, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0, 0, 321);
    chk("reacc_err_clr", ack_err, 1'b0);
    @(negedge clk);

    // reset in the middle of the address phase
    rw = 1'b0; dev_addr = 7'h2A; wr_data = 8'h00; start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      sda_i = !sda_oe;
    end
    chk("mid_addr", {scl_oe, sda_oe, busy}, 3'b111);
    reset = 1'b1;
    #1;
    chk("rst_mid", {scl_oe, sda_oe, busy}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    sda_i = 1'b1;
    rd_prev = 8'h00;
    chk("rst_mid_rd", rd_data, 8'h00);
    run_txn(1'b0, 7'h2A, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 0, 321);
    @(negedge clk);

    // fastest divider
    run2(1'b1, 89, 1'b1);
    run2(1'b0, 161, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
    run_stretch();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
- Bit-level I2C master engine that sits directly downstream of the protocol FSM (`m_P_FSM`).
- Consumes the FSM's `start` and returns the `finish` pulse that moves the FSM from ACTIVE to DONE.
- Executes one single-byte transaction: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Drives open-drain SCL/SDA enables toward the pad ring.

Parameters:
- CLK_DIV, 250: system clocks per quarter SCL period; legal range is 2 or more. Counter width is $clog2(CLK_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse or level; sampled only in IDLE.
- rw  input  1  0 = write, 1 = read; latched on accept.
- dev_addr  input  7  slave address; latched on accept.
- wr_data  input  8  write byte; latched on accept.
- rd_data  output  8  read byte; valid from finish onward.
- busy  output  1  high from accept until finish.
- finish  output  1  one-cycle completion pulse.
- ack_err  output  1  high if the slave NACKed address or write data; valid with finish; held until the next accept.
- scl_oe  output  1  1 = pull SCL low, 0 = release.
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- sda_i  input  1  SDA pad sense; assumed already synchronised.

Behaviour:
- Reset values:
  - State is IDLE.
  - scl_oe=0 and sda_oe=0 (bus released).
  - busy=0, finish=0, ack_err=0, rd_data=0.
  - Prescaler, quarter counter and bit counter are all 0.
- Accept:
  - In IDLE with start=1, latch rw, dev_addr and wr_data, clear ack_err, and set busy the next cycle.
  - start is ignored while busy.
- Timebase:
  - Prescaler counts 0..CLK_DIV-1 and issues a tick at wrap.
  - The 2-bit quarter counter q advances on each tick.
  - Every bit slot is four quarters. The prescaler restarts at 0 on accept.
- Data bit slot:
  - q0: scl_oe=1; SDA set to the bit (sda_oe = ~bit).
  - q1, q2: scl_oe=0; sda_i is sampled at the end of q2.
  - q3: scl_oe=1.
- States and transitions:
  - IDLE -> START on accept.
  - START (one slot): q0/q1 both released; q2 sda_oe=1; q3 scl_oe=1 and sda_oe=1. Then -> ADDR.
  - ADDR: 8 slots, sending {dev_addr, rw} MSB first. Then -> ADDR_ACK.
  - ADDR_ACK: 1 slot, SDA released. If sampled 1: ack_err=1 -> STOP. Otherwise -> WDATA when rw=0, RDATA when rw=1.
  - WDATA: 8 slots, wr_data MSB first. Then -> WACK.
  - WACK: 1 slot, SDA released. A sampled 1 sets ack_err. Then -> STOP.
  - RDATA: 8 slots, SDA released; shift sampled bits into a shift register MSB first. Then -> RNACK.
  - RNACK: 1 slot; master sends NACK (SDA released). Then -> STOP.
  - STOP (one slot): q0 scl_oe=1, sda_oe=1; q1 scl_oe=0, sda_oe=1; q2/q3 both released. Then -> DONE.
  - DONE: 1 clk. finish=1, busy=0, rd_data loaded from the shift register on reads (unchanged on writes). Then -> IDLE.
- Latency from the accept edge to the finish pulse:
  - Full transaction (20 slots): 80*CLK_DIV+1 clocks.
  - Address NACK (11 slots): 44*CLK_DIV+1 clocks.
- Bit counter: 3 bits, counts 7 down to 0. The state leaves ADDR/WDATA/RDATA when q3 ticks with count=0.
- Boundaries:
  - start held high through DONE re-accepts in IDLE on the next cycle.
  - Reset asserted mid-transaction immediately releases the bus, with no STOP generated.
  - CLK_DIV=2 must work with no dropped ticks.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- When defined:
  - Adds input scl_i (SCL pad sense, already synchronised).
  - While scl_oe=0 in q1/q2 and scl_i=0, the prescaler holds, so the slave stretches the clock.
  - Each stretch cycle extends latency by one clock.
- When undefined: the port is absent and timing is strictly open-loop, as specified above.

Test Plan:
- Write, CLK_DIV=4, dev_addr=0x50, wr_data=0xA5, slave ACKs both bytes:
  - SDA bits 1010000_0 then 10100101 on the SCL highs.
  - finish exactly 321 clocks after accept; ack_err=0.
- Read, dev_addr=0x68, slave drives 0x3C:
  - rd_data=0x3C at finish; master releases SDA in RNACK; ack_err=0.
- Address NACK (sda_i held 1), CLK_DIV=4:
  - No data slots; STOP issued.
  - finish at 177 clocks; ack_err=1.
- Write-data NACK only: full 321-clock transaction; ack_err=1.
- start pulsed again while busy is ignored. Reset asserted mid-ADDR:
  - scl_oe=0, sda_oe=0 and busy=0 on the same edge.
  - A new start afterwards completes normally.
- With I2C_CLK_STRETCH_EN, scl_i held low for 10 clocks in one q1: finish is delayed by exactly 10 clocks.
